// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM port arbiter.
// Defines the response-owner encoding and the starvation-counter sizing.
package sram_arb_pkg;

    localparam int STARVE_LIMIT_DEF = 4;
    localparam int STARVE_CNT_W     = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } resp_own_t;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Bundle of the core-side inst/data ports and the unified SRAM port.
// slave = arbiter view; master = core plus SRAM macro view.
interface sram_port_arbiter_if;

    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_gnt;
    logic        inst_rvalid;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;

    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    modport slave (
        input  inst_req, inst_addr,
        input  data_req, data_wen, data_addr, data_wdata,
        input  sram_rdata,
        output inst_gnt, inst_rvalid, inst_rdata,
        output data_gnt, data_rvalid, data_rdata,
        output sram_en, sram_wen, sram_addr, sram_wdata
    );

    modport master (
        output inst_req, inst_addr,
        output data_req, data_wen, data_addr, data_wdata,
        output sram_rdata,
        input  inst_gnt, inst_rvalid, inst_rdata,
        input  data_gnt, data_rvalid, data_rdata,
        input  sram_en, sram_wen, sram_addr, sram_wdata
    );

endinterface

// File: rtl/sram_port_arbiter_starve_ctr.sv
// Counts consecutive denied instruction-request cycles; raises inst_force at the limit.
// Registered count, combinational force; clears on grant or when the request drops.
module arb_starve_ctr
    import sram_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic resetn,
    input  logic inst_req,
    input  logic inst_gnt,
    output logic inst_force
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    logic [STARVE_CNT_W-1:0] cnt_q;
    logic [STARVE_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (inst_req && !inst_gnt) begin
            cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + STARVE_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign inst_force = (cnt_q == LIMIT);

endmodule

// File: rtl/sram_port_arbiter.sv
// Fixed-priority (data over inst) arbiter for one single-ported SRAM; 0-cycle grant, 1-cycle read return.
// Losing side waits with req held; ARB_STARVE_GUARD_EN adds a guard that forces an inst win after STARVE_LIMIT denials.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                clk,
    input  logic                resetn,
    sram_port_arbiter_if.slave  bus
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("STARVE_LIMIT must be within 1..15");
    end

    logic      inst_force;
    logic      data_win;
    logic      inst_win;
    resp_own_t own_q;
    resp_own_t own_d;

`ifdef ARB_STARVE_GUARD_EN
    arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk        (clk),
        .resetn     (resetn),
        .inst_req   (bus.inst_req),
        .inst_gnt   (inst_win),
        .inst_force (inst_force)
    );
`else
    assign inst_force = 1'b0;
`endif

    assign data_win = bus.data_req && !inst_force;
    assign inst_win = bus.inst_req && !data_win;

    always_comb begin
        bus.inst_gnt   = inst_win;
        bus.data_gnt   = data_win;
        bus.sram_en    = inst_win || data_win;
        bus.sram_wen   = data_win ? bus.data_wen : 4'b0000;
        bus.sram_addr  = 32'h0;
        bus.sram_wdata = 32'h0;
        if (data_win) begin
            bus.sram_addr  = bus.data_addr;
            bus.sram_wdata = bus.data_wdata;
        end else if (inst_win) begin
            bus.sram_addr  = bus.inst_addr;
        end
    end

    // Owner of the SRAM read data arriving next cycle; writes return nothing.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            own_q <= OWN_NONE;
        end else begin
            own_q <= own_d;
        end
    end

    always_comb begin
        own_d = OWN_NONE;
        if (inst_win) begin
            own_d = OWN_INST;
        end else if (data_win && (bus.data_wen == 4'b0000)) begin
            own_d = OWN_DATA;
        end
    end

    always_comb begin
        bus.inst_rvalid = (own_q == OWN_INST);
        bus.data_rvalid = (own_q == OWN_DATA);
        bus.inst_rdata  = (own_q == OWN_INST) ? bus.sram_rdata : 32'h0;
        bus.data_rdata  = (own_q == OWN_DATA) ? bus.sram_rdata : 32'h0;
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized and directed checks of sram_port_arbiter against a cycle-level behavioural model.
module tb_sram_port_arbiter;
    import sram_arb_pkg::*;

    localparam int LIM = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    sram_port_arbiter_if bus ();

    sram_port_arbiter #(
        .STARVE_LIMIT (LIM)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int exp_own;   // 0 none, 1 inst, 2 data: who gets the read data next cycle
    int waited;    // consecutive cycles the inst side has been refused
    bit last_ig, last_dg;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at posedge+1 with inputs driven; checks the cycle, advances the model, returns at next posedge+1.
    task automatic step();
        bit          frc, dw, iw;
        logic [31:0] xa, xwd;
        logic [3:0]  xwen;
        #1;
        frc  = GUARD && (waited >= LIM);
        dw   = bus.data_req && !frc;
        iw   = bus.inst_req && !dw;
        xa   = dw ? bus.data_addr : (iw ? bus.inst_addr : 32'h0);
        xwd  = dw ? bus.data_wdata : 32'h0;
        xwen = dw ? bus.data_wen : 4'h0;
        chk("data_gnt",    32'(bus.data_gnt),    32'(dw));
        chk("inst_gnt",    32'(bus.inst_gnt),    32'(iw));
        chk("sram_en",     32'(bus.sram_en),     32'(dw || iw));
        chk("sram_addr",   bus.sram_addr,        xa);
        chk("sram_wdata",  bus.sram_wdata,       xwd);
        chk("sram_wen",    32'(bus.sram_wen),    32'(xwen));
        chk("inst_rvalid", 32'(bus.inst_rvalid), 32'(exp_own == 1));
        chk("data_rvalid", 32'(bus.data_rvalid), 32'(exp_own == 2));
        chk("inst_rdata",  bus.inst_rdata,       (exp_own == 1) ? bus.sram_rdata : 32'h0);
        chk("data_rdata",  bus.data_rdata,       (exp_own == 2) ? bus.sram_rdata : 32'h0);
        exp_own = iw ? 1 : ((dw && bus.data_wen == 4'h0) ? 2 : 0);
        waited  = (bus.inst_req && !iw) ? waited + 1 : 0;
        last_ig = iw;
        last_dg = dw;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.inst_req   = 1'b0;
        bus.inst_addr  = 32'h0;
        bus.data_req   = 1'b0;
        bus.data_wen   = 4'h0;
        bus.data_addr  = 32'h0;
        bus.data_wdata = 32'h0;
        bus.sram_rdata = $urandom;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_own = 0;
        waited  = 0;
        resetn  = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sram_en",     32'(bus.sram_en),     32'h0);
        chk("rst_inst_rvalid", 32'(bus.inst_rvalid), 32'h0);
        chk("rst_data_rdata",  bus.data_rdata,       32'h0);
        resetn = 1'b1;
        step();

        // Instruction read alone
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'hBFC0_0000;
        #1;
        chk("ifetch_gnt",  32'(bus.inst_gnt), 32'h1);
        chk("ifetch_addr", bus.sram_addr,     32'hBFC0_0000);
        step();
        bus.inst_req   = 1'b0;
        bus.sram_rdata = 32'h3C1D_0001;
        #1;
        chk("ifetch_rvalid", 32'(bus.inst_rvalid), 32'h1);
        chk("ifetch_rdata",  bus.inst_rdata,       32'h3C1D_0001);
        step();

        // Simultaneous requests: data first, inst next
        bus.data_req  = 1'b1;
        bus.data_wen  = 4'h0;
        bus.data_addr = 32'h8000_1000;
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'hBFC0_0004;
        #1;
        chk("both_dgnt", 32'(bus.data_gnt), 32'h1);
        chk("both_ignt", 32'(bus.inst_gnt), 32'h0);
        step();
        bus.data_req   = 1'b0;
        bus.sram_rdata = $urandom;
        #1;
        chk("both_drv",   32'(bus.data_rvalid), 32'h1);
        chk("both_ignt2", 32'(bus.inst_gnt),    32'h1);
        step();
        bus.inst_req = 1'b0;
        #1;
        chk("both_irv", 32'(bus.inst_rvalid), 32'h1);
        step();

        // Data write produces no response
        bus.data_req   = 1'b1;
        bus.data_wen   = 4'b0011;
        bus.data_addr  = 32'h8000_2000;
        bus.data_wdata = 32'h0000_ABCD;
        #1;
        chk("wr_wen",   32'(bus.sram_wen), 32'h3);
        chk("wr_wdata", bus.sram_wdata,    32'h0000_ABCD);
        step();
        idle_inputs();
        #1;
        chk("wr_no_drv", 32'(bus.data_rvalid), 32'h0);
        chk("wr_no_irv", 32'(bus.inst_rvalid), 32'h0);
        step();

        // Both sides held high for ten cycles
        bus.data_req  = 1'b1;
        bus.data_wen  = 4'h0;
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'hBFC0_0100;
        for (int i = 0; i < 10; i++) begin
            bus.data_addr  = 32'h8000_0000 + 32'(i * 4);
            bus.sram_rdata = $urandom;
            #1;
            chk("starve_pattern", 32'(bus.inst_gnt), 32'(GUARD && (i % 5 == 4)));
            step();
        end
        idle_inputs();
        step();

        // Reset in the cycle after an inst grant discards the response
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'hBFC0_0200;
        step();
        bus.inst_req = 1'b0;
        resetn       = 1'b0;
        exp_own      = 0;
        waited       = 0;
        #1;
        chk("rst_mid_irv", 32'(bus.inst_rvalid), 32'h0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        chk("rst_after_irv", 32'(bus.inst_rvalid), 32'h0);
        step();

        // Random traffic with held requests and occasional abandonment
        for (int c = 0; c < 400; c++) begin
            if (!bus.inst_req || last_ig || $urandom_range(0, 15) == 0) begin
                bus.inst_req  = ($urandom_range(0, 3) != 0);
                bus.inst_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!bus.data_req || last_dg || $urandom_range(0, 15) == 0) begin
                bus.data_req   = ($urandom_range(0, 9) < ((c < 200) ? 9 : 5));
                bus.data_wen   = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom);
                bus.data_addr  = $urandom;
                bus.data_wdata = $urandom;
            end
            last_ig = 1'b0;
            last_dg = 1'b0;
            bus.sram_rdata = $urandom;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
